// File: rtl/disp_scan.sv
// disp_scan: reader side of the ALU digit-code interface.
// Takes one snapshot of all digit codes and the dot code per frame, then
// scans them one position at a time onto a common-anode 7-segment bank.
// Each position slot starts with a short all-anodes-off gap that stops
// the previous digit from ghosting onto the next anode.
module disp_scan #(
  parameter int DIGITS    = 18,
  parameter int SCAN_DIV  = 5000,
  parameter int BLANK_CYC = 50,
  parameter int DOT_POS   = 16
) (
  input  logic                  clk_DISP,
  input  logic                  rst_n,
  input  logic [6*DIGITS-1:0]   digit_bus,
  input  logic [5:0]            dot_code,
  output logic [DIGITS-1:0]     an_n,
  output logic [7:0]            seg_n,
  output logic                  frame_tick
);

  localparam int CNT_W = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
  localparam int POS_W = (DIGITS > 1) ? $clog2(DIGITS) : 1;

  localparam logic [CNT_W-1:0] CNT_LAST  = CNT_W'(SCAN_DIV - 1);
  localparam logic [CNT_W-1:0] BLANK_END = CNT_W'(BLANK_CYC);
  localparam logic [POS_W-1:0] POS_LAST  = POS_W'(DIGITS - 1);
  localparam logic [POS_W-1:0] DOT_IDX   = POS_W'(DOT_POS - 1);

  localparam logic [5:0] CODE_BLANK = 6'h3F;
  localparam logic [5:0] DOT_NONE   = 6'h20;
  localparam logic [5:0] DOT_ON     = 6'h21;

  logic [CNT_W-1:0]    div_cnt;
  logic [POS_W-1:0]    pos;
  logic [6*DIGITS-1:0] snap_digits;
  logic [5:0]          snap_dot;

  logic                tick;
  logic [5:0]          snap_arr [DIGITS];
  logic [5:0]          cur_code;
  logic [DIGITS-1:0]   an_next;
  logic [7:0]          seg_next;

  // Maps a digit code to its {g,f,e,d,c,b,a} pattern, active-high.
  function automatic logic [6:0] glyph(input logic [5:0] code);
    case (code)
      6'd0:    glyph = 7'h3F;
      6'd1:    glyph = 7'h06;
      6'd2:    glyph = 7'h5B;
      6'd3:    glyph = 7'h4F;
      6'd4:    glyph = 7'h66;
      6'd5:    glyph = 7'h6D;
      6'd6:    glyph = 7'h7D;
      6'd7:    glyph = 7'h07;
      6'd8:    glyph = 7'h7F;
      6'd9:    glyph = 7'h6F;
      6'd10:   glyph = 7'h40;
      6'd11:   glyph = 7'h79;
      6'd62:   glyph = 7'h46;
      6'd60:   glyph = 7'h76;
      6'd59:   glyph = 7'h5E;
      6'd58:   glyph = 7'h48;
      default: glyph = 7'h00;
    endcase
  endfunction

  // Split the packed snapshot into per-position codes so the scan index
  // can select one directly.
  for (genvar i = 0; i < DIGITS; i++) begin : g_split
    assign snap_arr[i] = snap_digits[6*i +: 6];
  end

  assign tick     = (div_cnt == CNT_LAST);
  assign cur_code = snap_arr[pos];

  // Slot divider: counts clocks within one position slot.
  always_ff @(posedge clk_DISP) begin
    if (!rst_n) begin
      div_cnt <= '0;
    end else if (tick) begin
      div_cnt <= '0;
    end else begin
      div_cnt <= div_cnt + 1'b1;
    end
  end

  // Position scan and frame snapshot: a new snapshot lands exactly as the
  // scan wraps back to position 1, so a frame never mixes two input sets.
  always_ff @(posedge clk_DISP) begin
    if (!rst_n) begin
      pos         <= '0;
      snap_digits <= {DIGITS{CODE_BLANK}};
      snap_dot    <= DOT_NONE;
    end else if (tick) begin
      if (pos == POS_LAST) begin
        pos         <= '0;
        snap_digits <= digit_bus;
        snap_dot    <= dot_code;
      end else begin
        pos <= pos + 1'b1;
      end
    end
  end

  // Next anode and segment pattern, derived only from registered state.
  always_comb begin
    an_next = '1;
    if (div_cnt >= BLANK_END) begin
      an_next[pos] = 1'b0;
    end
    seg_next      = 8'hFF;
    seg_next[6:0] = ~glyph(cur_code);
    seg_next[7]   = ~((pos == DOT_IDX) && (snap_dot == DOT_ON));
  end

  // Output registers keep the pins glitch-free and isolated from the inputs.
  always_ff @(posedge clk_DISP) begin
    if (!rst_n) begin
      an_n       <= '1;
      seg_n      <= 8'hFF;
      frame_tick <= 1'b0;
    end else begin
      an_n       <= an_next;
      seg_n      <= seg_next;
      frame_tick <= tick && (pos == POS_LAST);
    end
  end

endmodule
